// File: rtl/state_snapshot_cmp_pkg.sv
// Shared types and size helpers for the snapshot comparator.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package state_snapshot_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    FIN  = 2'd2
  } cmp_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int calc_nwords(input int state_w, input int word_w);
    return ceil_div(state_w, word_w);
  endfunction

  // Never narrower than one bit, even for a single-word state.
  function automatic int calc_idx_w(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

  // Must hold the value NWORDS itself (every word mismatching).
  function automatic int calc_cnt_w(input int nwords);
    return $clog2(nwords + 1);
  endfunction

  // Word pointer overshoots to at most NWORDS-1+LANES on the final step.
  function automatic int calc_ptr_w(input int nwords, input int lanes);
    return $clog2(nwords + lanes);
  endfunction

endpackage

// File: rtl/state_snapshot_cmp_if.sv
// Request/result bundle between the verification harness and the comparator.
// Latency: n/a (wires only).
// Backpressure: none; start is a pulse, start while busy is dropped by the slave.
interface state_snapshot_cmp_if
  import state_snapshot_cmp_pkg::*;
#(
  parameter int STATE_W = 1024,
  parameter int WORD_W  = 32
);
  localparam int NWORDS = calc_nwords(STATE_W, WORD_W);
  localparam int IDX_W  = calc_idx_w(NWORDS);
  localparam int CNT_W  = calc_cnt_w(NWORDS);

  logic               start;
  logic               abort;
  logic [STATE_W-1:0] state_src;
  logic [STATE_W-1:0] state_trg;
  logic [NWORDS-1:0]  word_mask;
  logic               busy;
  logic               done;
  logic               result_valid;
  logic               equal;
  logic [IDX_W-1:0]   mismatch_idx;
  logic [CNT_W-1:0]   mismatch_cnt;

  modport master (
    output start, abort, state_src, state_trg, word_mask,
    input  busy, done, result_valid, equal, mismatch_idx, mismatch_cnt
  );

  modport slave (
    input  start, abort, state_src, state_trg, word_mask,
    output busy, done, result_valid, equal, mismatch_idx, mismatch_cnt
  );

endinterface

// File: rtl/state_snapshot_cmp_lane_cmp.sv
// Compares LANES consecutive snapshot words starting at base, honouring the mask.
// Latency: combinational, zero cycles.
// Backpressure: none; lanes past the last word are simply ignored.
module state_lane_cmp
  import state_snapshot_cmp_pkg::*;
#(
  parameter int NWORDS = 32,
  parameter int WORD_W = 32,
  parameter int LANES  = 1,
  parameter int IDX_W  = 5,
  parameter int CNT_W  = 6,
  parameter int PTR_W  = 6
) (
  input  logic [NWORDS-1:0][WORD_W-1:0] snap_src,
  input  logic [NWORDS-1:0][WORD_W-1:0] snap_trg,
  input  logic [NWORDS-1:0]             mask,
  input  logic [PTR_W-1:0]              base,
  output logic [CNT_W-1:0]              hit_cnt,
  output logic                          hit_any,
  output logic [IDX_W-1:0]              hit_idx
);

  int              w;
  logic [IDX_W-1:0] wi;

  // Walk lanes high to low so the lowest mismatching word is written last.
  always_comb begin
    hit_cnt = '0;
    hit_any = 1'b0;
    hit_idx = '0;
    w       = 0;
    wi      = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      w = int'(base) + l;
      if (w < NWORDS) begin
        wi = IDX_W'(w);
        if (!mask[wi] && (snap_src[wi] != snap_trg[wi])) begin
          hit_cnt = hit_cnt + CNT_W'(1);
          hit_any = 1'b1;
          hit_idx = wi;
        end
      end
    end
  end

endmodule

// File: rtl/state_snapshot_cmp.sv
// Snapshots src/trg architectural state on start and compares it LANES words per cycle.
// Latency: done pulses ceil(NWORDS/LANES)+1 cycles after the start cycle.
// Backpressure: start while busy is ignored; abort cancels without a done pulse.
module state_snapshot_cmp
  import state_snapshot_cmp_pkg::*;
#(
  parameter int STATE_W = 1024,
  parameter int WORD_W  = 32,
  parameter int LANES   = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  state_snapshot_cmp_if.slave  cmp_if
);

  localparam int NWORDS = calc_nwords(STATE_W, WORD_W);
  localparam int IDX_W  = calc_idx_w(NWORDS);
  localparam int CNT_W  = calc_cnt_w(NWORDS);
  localparam int PTR_W  = calc_ptr_w(NWORDS, LANES);
  localparam int SNAP_W = NWORDS * WORD_W;

  typedef logic [NWORDS-1:0][WORD_W-1:0] snap_t;

  cmp_state_e       state, state_nxt;
  snap_t            src_ext, trg_ext;
  snap_t            snap_src, snap_trg;
  logic [NWORDS-1:0] snap_mask;
  logic [PTR_W-1:0] idx;
  logic [CNT_W-1:0] cnt, cnt_nxt, lane_cnt;
  logic [IDX_W-1:0] first_idx, lane_idx;
  logic             found, lane_any;
  logic             result_valid_q, equal_q;
  logic             accept, advance, last;

  // Zero-extension makes padding bits in the top word identical in both copies.
  assign src_ext = SNAP_W'(cmp_if.state_src);
  assign trg_ext = SNAP_W'(cmp_if.state_trg);

  assign accept  = (state == IDLE) && cmp_if.start;
  assign advance = (state == CMP) && !cmp_if.abort;
  assign last    = (int'(idx) + LANES) >= NWORDS;
  assign cnt_nxt = cnt + lane_cnt;

  state_lane_cmp #(
    .NWORDS (NWORDS),
    .WORD_W (WORD_W),
    .LANES  (LANES),
    .IDX_W  (IDX_W),
    .CNT_W  (CNT_W),
    .PTR_W  (PTR_W)
  ) u_lane_cmp (
    .snap_src (snap_src),
    .snap_trg (snap_trg),
    .mask     (snap_mask),
    .base     (idx),
    .hit_cnt  (lane_cnt),
    .hit_any  (lane_any),
    .hit_idx  (lane_idx)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: abort beats the final CMP->FIN step; FIN always lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmp_if.start) state_nxt = CMP;
      CMP: begin
        if (cmp_if.abort) state_nxt = IDLE;
        else if (last)    state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture on accept, accumulate while comparing, publish result when entering FIN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snap_src       <= '0;
      snap_trg       <= '0;
      snap_mask      <= '0;
      idx            <= '0;
      cnt            <= '0;
      first_idx      <= '0;
      found          <= 1'b0;
      result_valid_q <= 1'b0;
      equal_q        <= 1'b0;
    end else if (accept) begin
      snap_src       <= src_ext;
      snap_trg       <= trg_ext;
      snap_mask      <= cmp_if.word_mask;
      idx            <= '0;
      cnt            <= '0;
      first_idx      <= '0;
      found          <= 1'b0;
      result_valid_q <= 1'b0;
      equal_q        <= 1'b0;
    end else if (advance) begin
      cnt <= cnt_nxt;
      idx <= idx + PTR_W'(LANES);
      if (!found && lane_any) begin
        first_idx <= lane_idx;
        found     <= 1'b1;
      end
      if (last) begin
        result_valid_q <= 1'b1;
        equal_q        <= (cnt_nxt == '0);
      end
    end
  end

  assign cmp_if.busy         = (state == CMP);
  assign cmp_if.done         = (state == FIN);
  assign cmp_if.result_valid = result_valid_q;
  assign cmp_if.equal        = equal_q;
  assign cmp_if.mismatch_idx = first_idx;
  assign cmp_if.mismatch_cnt = cnt;

endmodule

// File: tb/tb_state_snapshot_cmp.sv
// Directed bench for two comparator configurations (96/32/1 and 80/32/2).
// Expected results are queued when a comparison is started and checked on done.
// Every wait on the DUT is bounded by a cycle budget.
module tb_state_snapshot_cmp;

  logic clock;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;
  int   lat      = 0;

  typedef struct {
    logic eq;
    int   idx;
    int   cnt;
    int   lat;
  } exp_t;

  exp_t sb[$];

  localparam logic [95:0] S_A  = 96'hDEADBEEF_01234567_89ABCDEF;
  localparam logic [95:0] D_W0 = 96'h00000000_00000000_00000100;
  localparam logic [95:0] D_W1 = 96'h00000000_00010000_00000000;
  localparam logic [95:0] D_W2 = 96'h00000001_00000000_00000000;
  localparam logic [95:0] S_B  = 96'h0_A5A5_11112222_33334444;
  localparam logic [95:0] D_B  = 96'h0_8000_00000001_00000000;

  state_snapshot_cmp_if #(.STATE_W(96), .WORD_W(32)) ifa ();
  state_snapshot_cmp_if #(.STATE_W(80), .WORD_W(32)) ifb ();

  state_snapshot_cmp #(.STATE_W(96), .WORD_W(32), .LANES(1)) dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .cmp_if  (ifa)
  );

  state_snapshot_cmp #(.STATE_W(80), .WORD_W(32), .LANES(2)) dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .cmp_if  (ifb)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    lat++;
  endtask

  task automatic expect_res(input logic eq, input int idx, input int cnt, input int l);
    exp_t e;
    e.eq  = eq;
    e.idx = idx;
    e.cnt = cnt;
    e.lat = l;
    sb.push_back(e);
  endtask

  // Drives a one-cycle start; afterwards lat counts cycles since the start cycle.
  task automatic kick(input bit sel_b, input logic [95:0] src, input logic [95:0] trg,
                      input logic [2:0] mask);
    if (sel_b) begin
      ifb.state_src = src[79:0];
      ifb.state_trg = trg[79:0];
      ifb.word_mask = mask;
      ifb.start     = 1'b1;
    end else begin
      ifa.state_src = src;
      ifa.state_trg = trg;
      ifa.word_mask = mask;
      ifa.start     = 1'b1;
    end
    lat = 0;
    step();
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  task automatic wait_done(input bit sel_b, input string tag);
    exp_t e;
    logic d;
    d = sel_b ? ifb.done : ifa.done;
    while (d !== 1'b1 && lat < 40) begin
      step();
      d = sel_b ? ifb.done : ifa.done;
    end
    check({tag, "_done"}, 32'(d), 32'd1);
    checks++;
    assert (sb.size() != 0)
    else begin
      failures++;
      $error("FAIL %s_sb: observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_lat"}, 32'(lat), 32'(e.lat));
      check({tag, "_equal"}, 32'(sel_b ? ifb.equal : ifa.equal), 32'(e.eq));
      check({tag, "_idx"}, 32'(sel_b ? ifb.mismatch_idx : ifa.mismatch_idx), 32'(e.idx));
      check({tag, "_cnt"}, 32'(sel_b ? ifb.mismatch_cnt : ifa.mismatch_cnt), 32'(e.cnt));
      check({tag, "_rv"}, 32'(sel_b ? ifb.result_valid : ifa.result_valid), 32'd1);
      check({tag, "_busy"}, 32'(sel_b ? ifb.busy : ifa.busy), 32'd0);
      step();
      check({tag, "_pulse"}, 32'(sel_b ? ifb.done : ifa.done), 32'd0);
      check({tag, "_hold"}, 32'(sel_b ? ifb.result_valid : ifa.result_valid), 32'd1);
    end
  endtask

  initial begin
    logic seen;
    reset_n       = 1'b0;
    ifa.start     = 1'b0;
    ifa.abort     = 1'b0;
    ifa.state_src = '0;
    ifa.state_trg = '0;
    ifa.word_mask = '0;
    ifb.start     = 1'b0;
    ifb.abort     = 1'b0;
    ifb.state_src = '0;
    ifb.state_trg = '0;
    ifb.word_mask = '0;

    // Reset values.
    #12;
    check("rst_busy", 32'(ifa.busy), 32'd0);
    check("rst_done", 32'(ifa.done), 32'd0);
    check("rst_rv", 32'(ifa.result_valid), 32'd0);
    check("rst_equal", 32'(ifa.equal), 32'd0);
    check("rst_idx", 32'(ifa.mismatch_idx), 32'd0);
    check("rst_cnt", 32'(ifa.mismatch_cnt), 32'd0);
    check("rst_busy_b", 32'(ifb.busy), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step();

    // 1: identical vectors.
    expect_res(1'b1, 0, 0, 4);
    kick(1'b0, S_A, S_A, 3'b000);
    check("t1_busy", 32'(ifa.busy), 32'd1);
    wait_done(1'b0, "t1");

    // 2: word 2 differs in bit 0.
    expect_res(1'b0, 2, 1, 4);
    kick(1'b0, S_A, S_A ^ D_W2, 3'b000);
    wait_done(1'b0, "t2");

    // 3: words 0 and 2 differ under several masks.
    expect_res(1'b0, 2, 1, 4);
    kick(1'b0, S_A, S_A ^ D_W0 ^ D_W2, 3'b001);
    wait_done(1'b0, "t3a");
    expect_res(1'b1, 0, 0, 4);
    ifa.abort = 1'b1;
    kick(1'b0, S_A, S_A ^ D_W0 ^ D_W2, 3'b101);
    ifa.abort = 1'b0;
    wait_done(1'b0, "t3b");
    expect_res(1'b1, 0, 0, 4);
    kick(1'b0, S_A, ~S_A, 3'b111);
    wait_done(1'b0, "t3c");

    // 4: snapshot holds after inputs change; start while busy is ignored.
    expect_res(1'b0, 1, 1, 4);
    kick(1'b0, S_A, S_A ^ D_W1, 3'b000);
    ifa.state_trg = S_A;
    ifa.start     = 1'b1;
    step();
    ifa.start = 1'b0;
    wait_done(1'b0, "t4");

    // 5: abort on the second CMP cycle.
    kick(1'b0, S_A, S_A ^ D_W0, 3'b000);
    step();
    ifa.abort = 1'b1;
    step();
    ifa.abort = 1'b0;
    check("t5_abort_busy", 32'(ifa.busy), 32'd0);
    check("t5_abort_rv", 32'(ifa.result_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | ifa.done;
      step();
    end
    check("t5_abort_nodone", 32'(seen), 32'd0);

    expect_res(1'b0, 0, 1, 4);
    kick(1'b0, S_A, S_A ^ D_W0, 3'b000);
    wait_done(1'b0, "t5_restart");

    // abort in IDLE leaves the held result alone.
    ifa.abort = 1'b1;
    step();
    ifa.abort = 1'b0;
    check("t5_idle_abort_rv", 32'(ifa.result_valid), 32'd1);
    check("t5_idle_abort_cnt", 32'(ifa.mismatch_cnt), 32'd1);

    // Reset in the middle of CMP clears outputs without a clock edge.
    kick(1'b0, S_A, S_A ^ D_W0, 3'b000);
    step();
    reset_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(ifa.busy), 32'd0);
    check("t5_rst_done", 32'(ifa.done), 32'd0);
    check("t5_rst_rv", 32'(ifa.result_valid), 32'd0);
    check("t5_rst_equal", 32'(ifa.equal), 32'd0);
    check("t5_rst_idx", 32'(ifa.mismatch_idx), 32'd0);
    check("t5_rst_cnt", 32'(ifa.mismatch_cnt), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | ifa.done;
      step();
    end
    check("t5_rst_nodone", 32'(seen), 32'd0);

    // 6: two lanes, padded top word; words 1 and 2 differ.
    expect_res(1'b0, 1, 2, 3);
    kick(1'b1, S_B, S_B ^ D_B, 3'b000);
    wait_done(1'b1, "t6");

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/state_snapshot_cmp.md
Name: state_snapshot_cmp

Overview:
- Parametrised successor to the flat per-copy state-extraction wrappers.
- Snapshots the flattened architectural state of the src and trg copies of the core (memories, regfile, CSRs, concatenated) on a start pulse.
- Compares the two snapshots word by word, LANES words per cycle, honouring a per-word exclusion mask.
- Reports equality, the first mismatching word index and the mismatch count to the relational-verification harness.

Parameters:
STATE_W, 1024, width of each flattened state vector (bits)
WORD_W, 32, comparison granule (bits)
LANES, 1, words compared per cycle (1..NWORDS)
Derived: NWORDS = ceil(STATE_W/WORD_W); IDX_W = max(1, clog2(NWORDS)); CNT_W = clog2(NWORDS+1)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request: capture inputs and begin comparison
abort  in  1  cancel an in-flight comparison
state_src  in  STATE_W  flattened state, src copy
state_trg  in  STATE_W  flattened state, trg copy
word_mask  in  NWORDS  bit i = 1 excludes word i from comparison
busy  out  1  capture/compare in progress
done  out  1  one-cycle pulse when the result is final
result_valid  out  1  result fields hold a completed comparison
equal  out  1  no unmasked word differs
mismatch_idx  out  IDX_W  lowest unmasked differing word index
mismatch_cnt  out  CNT_W  number of unmasked differing words

Behaviour:
- Reset (async assert, sync deassert inside the harness) forces FSM to IDLE and clears snapshots and counters.
- Reset values: busy=0, done=0, result_valid=0, equal=0, mismatch_idx=0, mismatch_cnt=0.
- FSM states: IDLE, CMP, FIN.
- IDLE + start: latch state_src, state_trg and word_mask into snapshot registers; zero idx, cnt and first-found flag; clear result_valid; go to CMP. busy=1 from the next cycle.
- Padding: word NWORDS-1 is zero-extended in both snapshots when STATE_W is not a multiple of WORD_W, so padding never mismatches.
- CMP, each cycle: compare words idx..idx+LANES-1.
  - Lanes with index >= NWORDS are ignored.
  - A word mismatches iff its snapshots differ and its mask bit is 0.
  - cnt += number of mismatching lanes this cycle.
  - If no mismatch has been found yet, record the lowest mismatching lane index this cycle in mismatch_idx.
  - idx += LANES.
  - When idx+LANES >= NWORDS, go to FIN.
- FIN (one cycle): done=1; result_valid=1; equal=(cnt==0); busy=0; go to IDLE.
- Latency: done asserts exactly ceil(NWORDS/LANES)+1 cycles after the start cycle. Results hold until the next accepted start or reset.
- Snapshot semantics: input changes after the start cycle have no effect on the result.
- start while busy: ignored; no restart, no error.
- abort in CMP: return to IDLE next cycle; busy=0; no done; result_valid stays 0. abort has priority over the FIN transition.
- abort in IDLE: no effect.
- start and abort together in IDLE: start wins.
- Reset mid-operation: immediate return to reset values; no done pulse.
- equal, mismatch_idx and mismatch_cnt are meaningful only when result_valid=1. With all words masked: equal=1, cnt=0, idx=0.
- cnt never overflows; CNT_W covers NWORDS.

Decomposition:
- Shared package: FSM state enum (IDLE/CMP/FIN), NWORDS/IDX_W/CNT_W derivation functions, and a ceil-div helper.
- One natural sub-module, state_lane_cmp: combinational compare of LANES words plus mask. Outputs a popcount and the lowest-index hit; instantiated once by the FSM.

Test Plan:
1. STATE_W=96, WORD_W=32, LANES=1; identical vectors, mask=0; start -> done 4 cycles later, equal=1, cnt=0, idx=0, result_valid=1.
2. Same config; trg word 2 = src word 2 ^ 0x1 -> equal=0, idx=2, cnt=1.
3. Words 0 and 2 differ, word_mask=3'b001 -> equal=0, idx=2, cnt=1. Same stimulus with word_mask=3'b101 -> equal=1, cnt=0.
4. Start with a differing word 1, then make inputs identical on the next cycle -> result still equal=0, idx=1 (snapshot holds). A second start while busy changes nothing.
5. Abort on 2nd CMP cycle -> busy=0 next cycle, no done, result_valid=0. A new start completes normally. Assert reset_n=0 mid-CMP -> all outputs 0 asynchronously.
6. STATE_W=80, WORD_W=32, LANES=2 (NWORDS=3, top 16 bits padded); words 1 and 2 differ -> done 3 cycles after start, idx=1, cnt=2.
